// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared state encoding, select codes and helpers for the RF write-port arbiter
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LD   = 2'b01;
  localparam logic [1:0] SEL_R7   = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  function automatic int burst_cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  // Reduce 0..4 into 0..2; the sum of a source index and a small offset never exceeds 4.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/rf_wr_port_arbiter_pick3.sv
// rtl/rf_wr_port_arbiter_pick3.sv - combinational picker: first eligible source scanning upward from start, wrapping mod 3
module pick3
  import rf_arb_pkg::*;
(
  input  logic [2:0] elig_i,
  input  logic [1:0] start_i,
  output logic [1:0] idx_o,
  output logic       vld_o
);

  always_comb begin
    idx_o = 2'd0;
    vld_o = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!vld_o && elig_i[wrap3({1'b0, start_i} + 3'(k))]) begin
        idx_o = wrap3({1'b0, start_i} + 3'(k));
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// rtl/rf_wr_port_arbiter.sv - RF write-port arbiter with locked bursts
// RF_WR_ARB_RR_EN defined: round-robin from rr_ptr+1; undefined: fixed priority 0 > 1 > 2.
module rf_wr_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int         BURST_MAX = 8,
  parameter logic [1:0] IDLE_SEL  = SEL_IDLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [2:0] lock,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       wr_en,
  output logic       busy
);

  localparam int            CW       = burst_cnt_width(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  arb_state_e    state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          wr_en_q, busy_q;
  logic [2:0]    eligible;
  logic [1:0]    start;
  logic [1:0]    win;
  logic          win_vld;

  assign eligible = req & ~((state_q == GNT) ? gnt_q : 3'b000);

`ifdef RF_WR_ARB_RR_EN
  assign start = wrap3({1'b0, rr_ptr_q} + 3'd1);
`else
  assign start = 2'd0;
`endif

  pick3 u_pick (
    .elig_i (eligible),
    .start_i(start),
    .idx_o  (win),
    .vld_o  (win_vld)
  );

  // In LOCK, sel_q holds the owner. burst_cnt_q counts beats already granted, so the
  // beat that brings the total to BURST_MAX is issued as the final (unlocked) beat.
  always_comb begin
    state_d     = IDLE;
    gnt_d       = 3'b000;
    sel_d       = IDLE_SEL;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = '0;
    if (state_q == LOCK) begin
      if (req[sel_q]) begin
        gnt_d       = 3'b001 << sel_q;
        sel_d       = sel_q;
        rr_ptr_d    = sel_q;
        burst_cnt_d = burst_cnt_q + CNT_ONE;
        state_d     = (lock[sel_q] && (burst_cnt_q < CNT_LAST)) ? LOCK : GNT;
      end
    end else if (win_vld) begin
      gnt_d       = 3'b001 << win;
      sel_d       = win;
      rr_ptr_d    = win;
      burst_cnt_d = CNT_ONE;
      state_d     = lock[win] ? LOCK : GNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 3'b000;
      sel_q       <= IDLE_SEL;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      rr_ptr_q    <= 2'd2;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      wr_en_q     <= |gnt_d;
      busy_q      <= (state_d == LOCK);
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign wr_en = wr_en_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// tb/tb_rf_wr_port_arbiter.sv - scoreboard bench for rf_wr_port_arbiter against a behavioural model
module tb_rf_wr_port_arbiter;

  localparam int BMAX = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] lock;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       wr_en;
  logic       busy;

  always #5 clk = ~clk;

  rf_wr_port_arbiter #(
    .BURST_MAX(BMAX),
    .IDLE_SEL (2'b11)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .lock (lock),
    .gnt  (gnt),
    .sel  (sel),
    .wr_en(wr_en),
    .busy (busy)
  );

  logic [6:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cycle  = 0;
  bit         started = 1'b0;
  string      phase = "reset";

  // Model: who owns an open burst, how many beats it has had, who was granted last
  // (without lock, hence blocked next time) and the round-robin pointer.
  bit m_in_burst;
  int m_owner, m_beats, m_blocked, m_rr;

  function automatic int choose(input logic [2:0] e, input int rr);
`ifdef RF_WR_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (e[(rr + k) % 3]) return (rr + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (e[k]) return k;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int         g;
    logic [2:0] e;
    g = -1;
    if (!rst_n) begin
      m_in_burst = 1'b0;
      m_owner    = -1;
      m_beats    = 0;
      m_blocked  = -1;
      m_rr       = 2;
    end else if (m_in_burst) begin
      if (req[m_owner]) begin
        g       = m_owner;
        m_beats = m_beats + 1;
        m_rr    = m_owner;
        if (!(lock[m_owner] && m_beats < BMAX)) begin
          m_in_burst = 1'b0;
          m_blocked  = m_owner;
        end
      end else begin
        m_in_burst = 1'b0;
        m_blocked  = -1;
      end
    end else begin
      e = req;
      if (m_blocked >= 0) e[m_blocked] = 1'b0;
      g = choose(e, m_rr);
      m_blocked = -1;
      if (g >= 0) begin
        m_rr = g;
        if (lock[g]) begin
          m_in_burst = 1'b1;
          m_owner    = g;
          m_beats    = 1;
        end else begin
          m_blocked = g;
        end
      end
    end
    exp_q.push_back({(g < 0) ? 3'b000 : 3'(1 << g),
                     (g < 0) ? 2'b11 : 2'(g),
                     (g >= 0),
                     m_in_burst});
    started = 1'b1;
  end

  always @(negedge clk) begin : monitor
    logic [6:0] x;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle=%0d phase=%s: no expected entry", cycle, phase);
      end else begin
        x = exp_q.pop_front();
        if ({gnt, sel, wr_en, busy} !== x) begin
          errors++;
          $display("FAIL outputs cycle=%0d phase=%s: got gnt=%b sel=%b wr_en=%b busy=%b, want gnt=%b sel=%b wr_en=%b busy=%b",
                   cycle, phase, gnt, sel, wr_en, busy, x[6:4], x[3:2], x[1], x[0]);
        end
      end
    end
  end

  task automatic cyc(input logic rn, input logic [2:0] r, input logic [2:0] l);
    rst_n = rn;
    req   = r;
    lock  = l;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b111;
    lock  = 3'b000;

    phase = "reset";
    repeat (3) cyc(1'b0, 3'b111, 3'b000);
    repeat (2) cyc(1'b1, 3'b111, 3'b000);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "single";
    cyc(1'b1, 3'b010, 3'b000);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "contention";
    repeat (6) cyc(1'b1, 3'b111, 3'b000);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "burst";
    repeat (4) cyc(1'b1, 3'b011, 3'b010);
    cyc(1'b1, 3'b011, 3'b000);
    repeat (2) cyc(1'b1, 3'b001, 3'b000);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "burst_cap";
    repeat (12) cyc(1'b1, 3'b011, 3'b010);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "reset_mid_burst";
    repeat (3) cyc(1'b1, 3'b010, 3'b010);
    cyc(1'b0, 3'b010, 3'b010);
    repeat (3) cyc(1'b1, 3'b010, 3'b010);
    repeat (2) cyc(1'b1, 3'b000, 3'b000);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          3'($urandom),
          ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom));
    end
    repeat (3) cyc(1'b1, 3'b000, 3'b000);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
